// File: rtl/ram_io_responder_pkg.sv
// Shared constants for the RAM/IO responder.
// Byte width and IO window decode values.
package ram_io_responder_pkg;

  localparam int MEM_WIDTH = 8;

  localparam logic [1:0] IO_SEL      = 2'b11;
  localparam logic [2:0] IO_DATA_OFS = 3'd0;
  localparam logic [2:0] IO_CTRL_OFS = 3'd4;

endpackage

// File: rtl/ram_io_responder_fifo.sv
// Byte FIFO with registered count and combinational head.
// A push to a full FIFO is accepted when a pop happens in the same cycle.
module byte_fifo
  import ram_io_responder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_in,
  input  logic                   push,
  input  logic                   pop,
  input  logic [MEM_WIDTH-1:0]   wdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [MEM_WIDTH-1:0]   head
);

  localparam int PW = $clog2(DEPTH);

  logic [MEM_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]        rptr_q, rptr_d;
  logic [PW-1:0]        wptr_q, wptr_d;
  logic [PW:0]          cnt_q, cnt_d;
  logic                 do_push, do_pop;

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == (PW+1)'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rptr_d  = rptr_q + PW'(do_pop);
    wptr_d  = wptr_q + PW'(do_push);
    cnt_d   = cnt_q + (PW+1)'(do_push)
                    - (PW+1)'(do_pop);
    count   = cnt_q;
    head    = mem_q[rptr_q];
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_io_responder.sv
// Byte RAM plus UART-style IO window answering the controller RAM port.
// IO window at a[17:16]=2'b11: TX/RX FIFOs, status byte, sticky halt.
module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter     INIT_FILE      = "",
  parameter int TX_DEPTH       = 8,
  parameter int RX_DEPTH       = 8,
  parameter int TX_GAP         = 4
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic [31:0]          mem_a,
  input  logic                 mem_rw,
  input  logic [MEM_WIDTH-1:0] mem_wdata,
  output logic [MEM_WIDTH-1:0] mem_rdata,
  output logic                 io_buffer_full,
  output logic                 tx_valid,
  output logic [MEM_WIDTH-1:0] tx_data,
  input  logic                 tx_ready,
  input  logic                 rx_valid,
  input  logic [MEM_WIDTH-1:0] rx_data,
  output logic                 rx_ready,
  output logic                 halt,
  output logic                 tx_overflow
);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_WAIT
  } tx_state_e;

  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;
  localparam int GW  = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;

  localparam logic [GW-1:0] GAP_LOAD = GW'(TX_GAP - 1);

  logic [MEM_WIDTH-1:0] ram_q [2**RAM_ADDR_WIDTH];

  logic [MEM_WIDTH-1:0] rdata_q, rdata_d;
  logic                 halt_q, halt_d;
  logic                 ovf_q, ovf_d;
  tx_state_e            state_q, state_d;
  logic [GW-1:0]        gap_q, gap_d;

  logic                 io_sel, io_rd;
  logic [2:0]           ofs;
  logic                 io_wr_data, io_wr_ctrl;
  logic                 io_rd_data;
  logic                 ram_we;
  logic [MEM_WIDTH-1:0] ram_rd;
  logic                 unused_a;

  logic                 tx_pop, tx_full, tx_empty;
  logic [TCW-1:0]       tx_count;
  logic [MEM_WIDTH-1:0] tx_head;
  logic                 rx_push, rx_full, rx_empty;
  logic                 rx_nonempty;
  logic [RCW-1:0]       rx_count;
  logic [MEM_WIDTH-1:0] rx_head;

  assign unused_a = ^mem_a;

  always_comb begin
    io_sel     = (mem_a[17:16] == IO_SEL);
    ofs        = mem_a[2:0];
    io_rd      = io_sel && !mem_rw;
    io_wr_data = io_sel && mem_rw
                 && (ofs == IO_DATA_OFS);
    io_wr_ctrl = io_sel && mem_rw
                 && (ofs == IO_CTRL_OFS);
    io_rd_data = io_rd
                 && (ofs == IO_DATA_OFS);
    ram_we     = !io_sel && mem_rw;
    ram_rd     = ram_q[mem_a[RAM_ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[mem_a[RAM_ADDR_WIDTH-1:0]] <= mem_wdata;
    end
  end

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_in(rst_in),
    .push  (io_wr_data),
    .pop   (tx_pop),
    .wdata (mem_wdata),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count),
    .head  (tx_head)
  );

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_in(rst_in),
    .push  (rx_push),
    .pop   (io_rd_data),
    .wdata (rx_data),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count),
    .head  (rx_head)
  );

  always_comb begin
    rx_nonempty = |rx_count;
    rx_ready    = !rx_full && !rst_in;
    rx_push     = rx_valid && rx_ready;
  end

  // Write cycles hold the last read byte.
  always_comb begin
    rdata_d = rdata_q;
    unique case (1'b1)
      mem_rw:
        rdata_d = rdata_q;
      !mem_rw && !io_sel:
        rdata_d = ram_rd;
      io_rd && (ofs == IO_DATA_OFS):
        rdata_d = rx_empty ? '0 : rx_head;
      io_rd && (ofs == IO_CTRL_OFS):
        rdata_d = {6'b0, rx_nonempty, tx_full};
      default:
        rdata_d = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      TX_IDLE: begin
        if (!tx_empty) state_d = TX_SEND;
      end
      TX_SEND: begin
        if (tx_ready) begin
          gap_d   = GAP_LOAD;
          state_d = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (gap_q <= GW'(1)) begin
          gap_d   = '0;
          state_d = tx_empty ? TX_IDLE : TX_SEND;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        state_d = TX_IDLE;
        gap_d   = '0;
      end
    endcase
  end

  always_comb begin
    tx_valid       = (state_q == TX_SEND);
    tx_data        = tx_valid ? tx_head : '0;
    tx_pop         = tx_valid && tx_ready;
    io_buffer_full = (tx_count >= TCW'(TX_DEPTH - 2));
    halt_d         = halt_q | io_wr_ctrl;
    ovf_d          = ovf_q
                     | (io_wr_data && tx_full && !tx_pop);
    halt           = halt_q;
    tx_overflow    = ovf_q;
    mem_rdata      = rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      rdata_q <= '0;
      halt_q  <= 1'b0;
      ovf_q   <= 1'b0;
      state_q <= TX_IDLE;
      gap_q   <= '0;
    end else begin
      rdata_q <= rdata_d;
      halt_q  <= halt_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

endmodule

// File: tb/tb_ram_io_responder.sv
// Scoreboard bench for ram_io_responder.
// Driver queues expected read bytes and TX bytes; monitor checks them.
module tb_ram_io_responder;

  logic        clk = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic        mem_rw;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        io_buffer_full;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        halt;
  logic        tx_overflow;

  ram_io_responder dut (
    .clk           (clk),
    .rst_in        (rst_in),
    .mem_a         (mem_a),
    .mem_rw        (mem_rw),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .io_buffer_full(io_buffer_full),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .halt          (halt),
    .tx_overflow   (tx_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         gap;
  } tx_exp_t;

  tx_exp_t    tx_q[$];
  logic [7:0] rd_q[$];
  string      rd_n[$];

  int   errs    = 0;
  int   checks  = 0;
  int   cyc     = 0;
  int   last_hs = -1;
  logic rd_chk  = 1'b0;
  logic rd_due  = 1'b0;

  task automatic chk(string n, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rd_due <= rd_chk;
  end

  always @(negedge clk) begin : monitor
    tx_exp_t    t;
    logic [7:0] e;
    string      n;
    if (rd_due) begin
      if (rd_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL rd_unexpected: got %0h want none",
                 mem_rdata);
      end else begin
        e = rd_q.pop_front();
        n = rd_n.pop_front();
        chk(n, mem_rdata, e);
      end
    end
    if (tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL tx_unexpected: got %0h want none",
                 tx_data);
      end else begin
        t = tx_q.pop_front();
        chk("tx_data", tx_data, t.d);
        if (t.gap > 0) chk("tx_gap", cyc - last_hs, t.gap);
      end
      last_hs = cyc;
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(logic [31:0] a, logic [7:0] d);
    mem_a     = a;
    mem_wdata = d;
    mem_rw    = 1'b1;
    @(posedge clk);
    #1;
    mem_rw = 1'b0;
    mem_a  = '0;
  endtask

  task automatic rd(string n, logic [31:0] a,
                    logic [7:0] e);
    rd_q.push_back(e);
    rd_n.push_back(n);
    mem_a  = a;
    mem_rw = 1'b0;
    rd_chk = 1'b1;
    @(posedge clk);
    #1;
    rd_chk = 1'b0;
    mem_a  = '0;
  endtask

  task automatic pulse_reset();
    rst_in = 1'b1;
    idle(1);
    rst_in = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_in    = 1'b1;
    mem_a     = '0;
    mem_rw    = 1'b0;
    mem_wdata = '0;
    tx_ready  = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = '0;
    repeat (2) @(posedge clk);
    #1;

    chk("rst_rdata", mem_rdata, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_halt", halt, 0);
    chk("rst_ovf", tx_overflow, 0);
    chk("rst_iobf", io_buffer_full, 0);
    chk("rst_rx_ready", rx_ready, 0);
    rst_in = 1'b0;
    #1;
    chk("rx_ready_run", rx_ready, 1);
    idle(1);

    wr(32'h0001_0, 8'hA5);
    rd("ram_rd", 32'h0001_0, 8'hA5);
    wr(32'h1_FFFF, 8'h3C);
    rd("ram_top", 32'h1_FFFF, 8'h3C);
    rd("ram_alias", 32'h2_0010, 8'hA5);
    rd("io_ofs1", 32'h3_0001, 8'h00);

    tx_ready = 1'b1;
    tx_q.push_back('{8'h41, 0});
    tx_q.push_back('{8'h42, 4});
    tx_q.push_back('{8'h43, 4});
    wr(32'h3_0000, 8'h41);
    wr(32'h3_0000, 8'h42);
    wr(32'h3_0000, 8'h43);
    for (int i = 0; i < 100 && tx_q.size() != 0; i++)
      idle(1);
    chk("tx_drain_left", tx_q.size(), 0);
    idle(6);
    tx_ready = 1'b0;

    for (int i = 0; i < 6; i++) begin
      wr(32'h3_0000, 8'h50 + 8'(i));
      chk($sformatf("iobf_push%0d", i + 1),
          io_buffer_full, (i >= 5) ? 1 : 0);
    end
    wr(32'h3_0000, 8'h56);
    chk("ovf_push7", tx_overflow, 0);
    wr(32'h3_0000, 8'h57);
    chk("ovf_push8", tx_overflow, 0);
    rd("status_txfull", 32'h3_0004, 8'h01);
    wr(32'h3_0000, 8'h58);
    chk("ovf_push9", tx_overflow, 1);
    chk("tx_head_hold", tx_data, 8'h50);
    pulse_reset();
    chk("ovf_cleared", tx_overflow, 0);
    chk("iobf_cleared", io_buffer_full, 0);

    rx_valid = 1'b1;
    rx_data  = 8'h7E;
    idle(1);
    rx_valid = 1'b0;
    rd("rx_status", 32'h3_0004, 8'h02);
    rd("rx_pop", 32'h3_0000, 8'h7E);
    rd("rx_empty_rd", 32'h3_0000, 8'h00);
    chk("rx_ready_after", rx_ready, 1);

    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'h10 + 8'(i);
      idle(1);
    end
    rx_valid = 1'b0;
    chk("rx_ready_full", rx_ready, 0);
    rd("rx_fifo_head", 32'h3_0000, 8'h10);
    chk("rx_ready_refill", rx_ready, 1);

    wr(32'h3_0004, 8'h5A);
    chk("halt_set", halt, 1);
    wr(32'h0000_40, 8'h01);
    rd("ram_after_halt", 32'h0000_40, 8'h01);
    chk("halt_sticky", halt, 1);

    wr(32'h3_0000, 8'h61);
    wr(32'h3_0000, 8'h62);
    wr(32'h3_0000, 8'h63);
    idle(1);
    chk("tx_valid_queued", tx_valid, 1);
    chk("tx_data_queued", tx_data, 8'h61);
    pulse_reset();
    chk("tx_valid_rst", tx_valid, 0);
    chk("iobf_rst", io_buffer_full, 0);
    chk("halt_rst", halt, 0);
    rd("status_rst", 32'h3_0004, 8'h00);
    idle(3);

    chk("rd_q_left", rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
